// File: rtl/keypad_pkg.sv
// Shared types and constants for the hex keypad scanner.
//   db_state_t    : debounce FSM states
//   scan_result_t : classification of one full four-column scan
//   KEYMAP        : [row][col] -> 4-bit key code, col 0 is col_n[0]
//   count_hits    : number of asserted rows in one column sample, saturating at 2
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } db_state_t;

  typedef enum logic [1:0] {
    NONE,
    KEY,
    MULTI
  } scan_result_t;

  localparam logic [0:3][0:3][3:0] KEYMAP = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // 0, 1, or 2 meaning "two or more"; that is all the ghosting reject needs.
  function automatic logic [1:0] count_hits(input logic [3:0] hits);
    logic [2:0] n;
    n = 3'(hits[0]) + 3'(hits[1]) + 3'(hits[2]) + 3'(hits[3]);
    return (n > 3'd1) ? 2'd2 : n[1:0];
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounce FSM for the keypad scanner, evaluated once per completed scan.
//   clk, rstn  : clock, synchronous active-low reset
//   scan_done  : one-cycle strobe at the end of each full scan
//   result     : NONE / KEY / MULTI for the scan that is ending
//   code       : key code when result is KEY
//   accept     : combinational, high in the scan_done cycle that accepts a press
//   key_held   : registered, 1 from accepted press until accepted release
//   cand       : code being accepted; valid whenever accept is high
//
// state        | meaning
// IDLE         | no key, waiting for a single-key scan
// PRESS_WAIT   | same key seen cnt scans in a row, not yet accepted
// HELD         | press accepted, waiting for an empty scan
// RELEASE_WAIT | cnt empty scans in a row, release not yet accepted
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         scan_done,
  input  scan_result_t result,
  input  logic [3:0]   code,
  output logic         accept,
  output logic         key_held,
  output logic [3:0]   cand
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

  db_state_t     state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    cand_q;
  logic          key_match;

  always_comb begin
    cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    // In IDLE the candidate is only being captured this cycle, so expose the
    // incoming code; this is what makes a single-scan debounce work.
    cand      = (state == IDLE) ? code : cand_q;
    key_match = (result == KEY) && (code == cand_q);
    accept    = 1'b0;
    if (scan_done && result == KEY) begin
      case (state)
        IDLE:       accept = (DEBOUNCE_SCANS == 1);
        PRESS_WAIT: accept = key_match && (cnt_inc == CNT_MAX);
        default:    accept = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      cand_q   <= 4'h0;
      key_held <= 1'b0;
    end else if (scan_done) begin
      case (state)
        IDLE: begin
          if (result == KEY) begin
            cand_q <= code;
            cnt    <= CW'(1);
            if (accept) begin
              state    <= HELD;
              key_held <= 1'b1;
            end else begin
              state <= PRESS_WAIT;
            end
          end
        end
        PRESS_WAIT: begin
          if (key_match) begin
            cnt <= cnt_inc;
            if (accept) begin
              state    <= HELD;
              key_held <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        HELD: begin
          if (result == NONE) begin
            cnt <= CW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              state    <= IDLE;
              key_held <= 1'b0;
            end else begin
              state <= RELEASE_WAIT;
            end
          end
        end
        RELEASE_WAIT: begin
          if (result == NONE) begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state    <= IDLE;
              key_held <= 1'b0;
            end
          end else begin
            state <= HELD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex matrix keypad scanner with debounce and an 8-digit key history.
//   clk, rstn  : clock, synchronous active-low reset
//   row_n[3:0] : keypad rows, active low, asynchronous to clk
//   clear      : zero the digit history on the next edge
//   col_n[3:0] : one-hot-low column strobe, rotates every CYCLE_PER_COL cycles
//   key_valid  : one-cycle pulse per accepted press
//   key_code   : code of the last accepted key, held between pulses
//   key_held   : 1 from accepted press until accepted release
//   digits     : last 8 accepted keys, newest in [3:0]
module hex_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CYCLE_PER_COL  = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  row_n,
  input  logic        clear,
  output logic [3:0]  col_n,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_held,
  output logic [31:0] digits
);

  localparam int CCW = $clog2(CYCLE_PER_COL);

  logic [3:0]     row_s1;
  logic [3:0]     row_s2;
  logic [CCW-1:0] col_cnt;
  logic [1:0]     col_idx;
  logic           col_tc;
  logic           scan_done;

  logic [3:0]     row_hit;
  logic [1:0]     row_sel;
  logic [1:0]     cur_n;
  logic [3:0]     cur_code;
  logic [2:0]     sum_n;
  logic [1:0]     tot_n;
  logic [3:0]     tot_code;
  logic [1:0]     acc_n;
  logic [3:0]     acc_code;
  scan_result_t   result;

  logic           accept;
  logic [3:0]     cand;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
    end
  end

  // Rows are only looked at on the terminal count, long after the strobe
  // change has propagated through the synchronizer.
  assign col_tc    = (col_cnt == CCW'(CYCLE_PER_COL - 1));
  assign scan_done = col_tc && (col_idx == 2'd3);
  assign row_hit   = ~row_s2;

  // Merge the current column sample into the running scan tally.
  always_comb begin
    casez (row_hit)
      4'b???1: row_sel = 2'd0;
      4'b??10: row_sel = 2'd1;
      4'b?100: row_sel = 2'd2;
      4'b1000: row_sel = 2'd3;
      default: row_sel = 2'd0;
    endcase
    cur_n    = count_hits(row_hit);
    cur_code = KEYMAP[row_sel][col_idx];
    sum_n    = 3'(acc_n) + 3'(cur_n);
    tot_n    = (sum_n > 3'd1) ? 2'd2 : sum_n[1:0];
    tot_code = (acc_n != 2'd0) ? acc_code : cur_code;
    case (tot_n)
      2'd0:    result = NONE;
      2'd1:    result = KEY;
      default: result = MULTI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      col_cnt  <= '0;
      col_idx  <= 2'd0;
      col_n    <= 4'b1110;
      acc_n    <= 2'd0;
      acc_code <= 4'h0;
    end else if (col_tc) begin
      col_cnt <= '0;
      col_idx <= col_idx + 2'd1;
      col_n   <= {col_n[2:0], col_n[3]};
      if (col_idx == 2'd3) begin
        acc_n    <= 2'd0;
        acc_code <= 4'h0;
      end else begin
        acc_n    <= tot_n;
        acc_code <= tot_code;
      end
    end else begin
      col_cnt <= col_cnt + CCW'(1);
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk      (clk),
    .rstn     (rstn),
    .scan_done(scan_done),
    .result   (result),
    .code     (tot_code),
    .accept   (accept),
    .key_held (key_held),
    .cand     (cand)
  );

  // An accept coinciding with clear keeps only the new key.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      digits    <= 32'h0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= cand;
        digits   <= clear ? {28'h0, cand} : {digits[27:0], cand};
      end else if (clear) begin
        digits <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
module tb_hex_keypad_scanner;

  localparam int CPC  = 4;
  localparam int DS   = 3;
  localparam int SCAN = 4 * CPC;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  row_n;
  logic        clear;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [31:0] digits;

  logic [15:0] mask;  // bit r*4+c = key at row r, column c pressed

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  hex_keypad_scanner #(
    .CYCLE_PER_COL (CPC),
    .DEBOUNCE_SCANS(DS)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .row_n    (row_n),
    .clear    (clear),
    .col_n    (col_n),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_held (key_held),
    .digits   (digits)
  );

  // Passive keypad: a row is pulled low when a pressed key sits on the strobed column.
  assign row_n[0] = ~|(mask[3:0]   & ~col_n);
  assign row_n[1] = ~|(mask[7:4]   & ~col_n);
  assign row_n[2] = ~|(mask[11:8]  & ~col_n);
  assign row_n[3] = ~|(mask[15:12] & ~col_n);

  function automatic logic [3:0] key_of(input int idx);
    case (idx)
      0: return 4'h1;   1: return 4'h2;   2: return 4'h3;   3: return 4'hA;
      4: return 4'h4;   5: return 4'h5;   6: return 4'h6;   7: return 4'hB;
      8: return 4'h7;   9: return 4'h8;  10: return 4'h9;  11: return 4'hC;
      12: return 4'hE; 13: return 4'h0;  14: return 4'hF;  15: return 4'hD;
      default: return 4'h0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mk counts clock edges since reset; the row value seen at a column's terminal
  // count is the key mask from two edges earlier (synchronizer depth).
  localparam int PH_IDLE = 0, PH_PRESS = 1, PH_HELD = 2, PH_REL = 3;
  int          mk;
  logic [15:0] h0, h1;
  int          sc_hits;
  logic [3:0]  sc_code;
  int          ph, m_cnt;
  logic [3:0]  m_cand;
  bit          m_acc;
  logic        m_valid, m_held;
  logic [3:0]  m_code;
  logic [31:0] m_digits;

  always @(posedge clk) begin
    int c;
    if (!rstn) begin
      mk = 0; h0 = '0; h1 = '0; sc_hits = 0; sc_code = 0;
      ph = PH_IDLE; m_cnt = 0; m_cand = 0;
      m_valid = 0; m_held = 0; m_code = 0; m_digits = 0;
    end else begin
      m_valid = 1'b0;
      m_acc   = 1'b0;
      if ((mk % CPC) == CPC - 1) begin
        c = (mk / CPC) % 4;
        for (int r = 0; r < 4; r++)
          if (h1[r*4+c]) begin
            sc_hits++;
            sc_code = key_of(r*4+c);
          end
        if (c == 3) begin
          case (ph)
            PH_IDLE:
              if (sc_hits == 1) begin
                m_cand = sc_code; m_cnt = 1;
                if (m_cnt >= DS) m_acc = 1; else ph = PH_PRESS;
              end
            PH_PRESS:
              if (sc_hits == 1 && sc_code == m_cand) begin
                m_cnt++;
                if (m_cnt >= DS) m_acc = 1;
              end else ph = PH_IDLE;
            PH_HELD:
              if (sc_hits == 0) begin
                m_cnt = 1;
                if (m_cnt >= DS) begin ph = PH_IDLE; m_held = 0; end else ph = PH_REL;
              end
            default:
              if (sc_hits == 0) begin
                m_cnt++;
                if (m_cnt >= DS) begin ph = PH_IDLE; m_held = 0; end
              end else ph = PH_HELD;
          endcase
          sc_hits = 0;
        end
      end
      if (m_acc) begin
        m_valid = 1; m_code = m_cand; m_held = 1; ph = PH_HELD;
        m_digits = clear ? {28'h0, m_cand} : {m_digits[27:0], m_cand};
      end else if (clear) begin
        m_digits = 32'h0;
      end
      h1 = h0;
      h0 = mask;
      mk++;
    end
  end

  always @(negedge clk) begin
    logic [3:0] e_col;
    if (chk_en) begin
      e_col = ~(4'b0001 << ((mk / CPC) % 4));
      check("col_n", 32'(col_n), 32'(e_col));
      check("key_valid", 32'(key_valid), 32'(m_valid));
      check("key_code", 32'(key_code), 32'(m_code));
      check("key_held", 32'(key_held), 32'(m_held));
      check("digits", digits, m_digits);
      if (key_valid === 1'b1) pulses++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic scans(input int n);
    repeat (n * SCAN) @(negedge clk);
  endtask

  task automatic align();
    @(negedge clk);
    for (int i = 0; i < SCAN && (mk % SCAN) != 0; i++) @(negedge clk);
  endtask

  task automatic press_release(input int idx);
    align();
    mask = 16'(1 << idx);
    scans(4);
    mask = '0;
    scans(4);
  endtask

  initial begin
    int a, b, sel;
    logic [15:0] m;
    rstn = 1'b0; clear = 1'b0; mask = '0;
    repeat (2) @(negedge clk);
    check("reset col_n", 32'(col_n), 32'h0000000E);
    check("reset digits", digits, 32'h0);
    chk_en = 1'b1;
    rstn = 1'b1;

    // 1: idle keypad
    scans(100);
    check("idle pulses", 32'(pulses), 32'd0);
    check("idle digits", digits, 32'h0);

    // 2: hold '5'
    align();
    mask = 16'(1 << 5);
    scans(25);
    check("hold5 pulses", 32'(pulses), 32'd1);
    check("hold5 code", 32'(key_code), 32'h5);
    check("hold5 digits", digits, 32'h00000005);
    check("hold5 held", 32'(key_held), 32'd1);
    mask = '0;
    scans(4);
    check("rel5 held", 32'(key_held), 32'd0);

    // 3: bounce on press and release of '9'
    align();
    mask = 16'(1 << 10); scans(1);
    mask = '0;           scans(1);
    mask = 16'(1 << 10); scans(1);
    mask = '0;           scans(1);
    mask = 16'(1 << 10); scans(6);
    check("bounce9 pulses", 32'(pulses), 32'd2);
    check("bounce9 code", 32'(key_code), 32'h9);
    mask = '0;           scans(1);
    mask = 16'(1 << 10); scans(1);
    check("relbounce held", 32'(key_held), 32'd1);
    mask = '0;           scans(4);
    check("relbounce pulses", 32'(pulses), 32'd2);
    check("rel9 held", 32'(key_held), 32'd0);

    // 4: ghosting reject
    align();
    mask = 16'h0003;
    scans(10);
    check("multi pulses", 32'(pulses), 32'd2);
    check("multi digits", digits, 32'h00000059);
    mask = '0;
    scans(2);

    // 5: sequence 1,2,3,A,4,5,6,B,7
    press_release(0); press_release(1); press_release(2); press_release(3);
    press_release(4); press_release(5); press_release(6); press_release(7);
    press_release(8);
    check("seq pulses", 32'(pulses), 32'd11);
    check("seq digits", digits, 32'h23A456B7);

    // 6a: clear coinciding with the 'D' accept
    align();
    mask = 16'(1 << 15);
    repeat (3 * SCAN - 1) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clrD valid", 32'(key_valid), 32'd1);
    check("clrD digits", digits, 32'h0000000D);
    check("clrD code", 32'(key_code), 32'hD);
    mask = '0;
    scans(5);

    // 6b: reset during PRESS_WAIT
    align();
    mask = 16'(1 << 9);
    scans(1);
    repeat (SCAN / 2) @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    mask = '0;
    check("rst col_n", 32'(col_n), 32'h0000000E);
    check("rst held", 32'(key_held), 32'd0);
    check("rst code", 32'(key_code), 32'h0);
    check("rst digits", digits, 32'h0);
    scans(4);
    check("rst pulses", 32'(pulses), 32'd12);

    // random traffic: singles, empties, pairs, unaligned changes, stray clears
    for (int i = 0; i < 250; i++) begin
      sel = $urandom_range(0, 9);
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      if (sel < 3)      m = '0;
      else if (sel < 8) m = 16'(1 << a);
      else              m = 16'((1 << a) | (1 << b));
      repeat ($urandom_range(1, 6 * SCAN)) @(negedge clk);
      mask = m;
      if ($urandom_range(0, 19) == 0) begin
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
      end
    end
    mask = '0;
    scans(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
